rr_pkt_arb: RTL and testbench
=============================

RR_PKT_ARB -- requirements
Module: rr_pkt_arb

Interface
REQ-001 SHALL have parameter PORT, default 4: highest requester index, giving PORT+1 requesters.
REQ-002 SHALL have parameter CRED, default 4: downstream buffer depth, which is also the credit reset value.
REQ-003 SHALL have parameter CW, default 3: credit counter width, with 2^CW > CRED.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_, input, 1 bit: reset, synchronous and active-high despite the name.
REQ-006 SHALL have port req, input, [PORT:0]: per-requester head-flit-valid.
REQ-007 SHALL have port tail, input, [PORT:0]: per-requester flag marking the current head flit as a packet tail.
REQ-008 SHALL have port cred_in, input, 1 bit: one-cycle pulse returning one downstream credit.
REQ-009 SHALL have port grt, output, [PORT:0]: registered one-hot grant, held for the whole packet.
REQ-010 SHALL have port busy, output, 1 bit: high while in HOLD.
REQ-011 SHALL have port fire, output, 1 bit: combinational flit-transfer strobe.
REQ-012 SHALL have port cred_cnt, output, [CW-1:0]: current credit count.
REQ-013 SHALL have port cred_err, output, 1 bit: sticky credit-overflow flag.

Function
REQ-014 SHALL implement a two-state FSM: IDLE (grt==0) and HOLD (grt one-hot).
REQ-015 In IDLE with req!=0, SHALL pick the first set req bit, searching round-robin upward from pointer ptr and wrapping PORT->0.
REQ-016 The IDLE pick SHALL register the winner's bit into grt, enter HOLD and set ptr = winner+1 (PORT+1 wraps to 0), all at the next edge; grant latency is 1 cycle from req.
REQ-017 Arbitration SHALL ignore cred_cnt: a grant may be issued with zero credits.
REQ-018 In IDLE with req==0, state, grt and ptr SHALL hold.
REQ-019 fire SHALL = busy & |(grt & req) & (cred_cnt != 0); otherwise fire is 0.
REQ-020 In HOLD, grt SHALL stay constant while the owner's req deasserts mid-packet (wormhole hold); fire is 0 in those cycles.
REQ-021 On fire with tail[owner]==1: next edge SHALL clear grt and enter IDLE; a single-flit packet (head = tail) releases on its first fire.
REQ-022 The release edge SHALL leave exactly one IDLE cycle before the next grant (1-cycle bubble); back-to-back packets cost 1 bubble.
REQ-023 tail bits of non-owners SHALL be ignored; tail[owner] SHALL be ignored when fire==0.
REQ-024 Credit update per edge SHALL be: fire&!cred_in -> cnt-1; cred_in&!fire -> cnt+1; both or neither -> unchanged.
REQ-025 cred_in arriving when cnt==CRED and fire==0 SHALL leave cnt at CRED (saturate) and set cred_err, which stays set until reset.
REQ-026 cnt SHALL never underflow, guaranteed by the fire gating in REQ-019.
REQ-027 At most one grt bit SHALL ever be set.
REQ-028 grt SHALL change only on an IDLE->HOLD or HOLD->IDLE edge.

Reset
REQ-029 With rst_==1 at an edge, SHALL set state=IDLE, grt=0, busy=0, ptr=0, cred_cnt=CRED, cred_err=0.
REQ-030 Reset SHALL take priority over all other updates, including mid-packet; the interrupted packet is abandoned and no release is required.
REQ-031 fire SHALL be 0 whenever busy==0, including during reset.

Verification
REQ-032 After reset, req=5'b10100 -> grt=5'b00100 one cycle later, busy=1, ptr=3; after that packet's tail, req still 5'b10100 -> next grant 5'b10000.
REQ-033 Single-flit packet: req[0]=1, tail[0]=1, cred=4 -> fire high in the first HOLD cycle; cred_cnt becomes 3; grt=0 on the next edge; next grant 2 edges later.
REQ-034 Credit starvation: owner streams a 6-flit packet with CRED=4 and no cred_in -> 4 fires, then fire=0 with grt held; one cred_in pulse -> exactly one further fire.
REQ-035 Simultaneous cred_in and fire at cnt=2 -> cnt stays 2; cred_in at cnt=4 with no fire -> cnt stays 4 and cred_err=1, sticky.
REQ-036 Mid-packet reset while grt=5'b01000 and cnt=1 -> next edge grt=0, cnt=4, ptr=0; then req=5'b11111 -> grt=5'b00001.
REQ-037 Owner deasserts req for 3 cycles mid-packet while others request -> grt unchanged, fire=0 for those 3 cycles, no other grant issued.

Source files
------------

// File: rtl/rr_pkt_arb.sv
// Round-robin packet arbiter with wormhole grant hold and downstream credit tracking.
// A grant is held from the head flit to the tail flit. Flits move only while credits remain.
module rr_pkt_arb #(
  parameter int unsigned PORT = 4,
  parameter int unsigned CRED = 4,
  parameter int unsigned CW   = 3
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic [PORT:0]   req,
  input  logic [PORT:0]   tail,
  input  logic            cred_in,
  output logic [PORT:0]   grt,
  output logic            busy,
  output logic            fire,
  output logic [CW-1:0]   cred_cnt,
  output logic            cred_err
);

  localparam int unsigned NREQ = PORT + 1;
  localparam int unsigned PW   = (PORT > 0) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state_q, state_d;
  logic [PORT:0]   grt_q, grt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cred_q, cred_d;
  logic            err_q, err_d;

  logic            pick_vld;
  logic [PW-1:0]   pick_idx;
  logic            owner_tail;

  // Round-robin search upward from ptr_q, wrapping PORT -> 0.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(ptr_q) + i) % NREQ;
      if (!pick_vld && req[PW'(idx)]) begin
        pick_vld = 1'b1;
        pick_idx = PW'(idx);
      end
    end
  end

  assign busy       = (state_q == HOLD);
  assign fire       = busy && (|(grt_q & req)) && (cred_q != '0);
  assign owner_tail = |(grt_q & tail);

  // Next-state, grant, pointer and credit logic.
  always_comb begin
    state_d = state_q;
    grt_d   = grt_q;
    ptr_d   = ptr_q;
    cred_d  = cred_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d        = HOLD;
          grt_d          = '0;
          grt_d[pick_idx] = 1'b1;
          ptr_d          = (pick_idx == PW'(PORT)) ? '0 : pick_idx + PW'(1);
        end
      end
      HOLD: begin
        if (fire && owner_tail) begin
          state_d = IDLE;
          grt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Credit returned while full saturates and raises the sticky error.
    if (fire && !cred_in) begin
      cred_d = cred_q - CW'(1);
    end else if (cred_in && !fire) begin
      if (cred_q == CW'(CRED)) begin
        err_d = 1'b1;
      end else begin
        cred_d = cred_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q <= IDLE;
      grt_q   <= '0;
      ptr_q   <= '0;
      cred_q  <= CW'(CRED);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grt_q   <= grt_d;
      ptr_q   <= ptr_d;
      cred_q  <= cred_d;
      err_q   <= err_d;
    end
  end

  assign grt      = grt_q;
  assign cred_cnt = cred_q;
  assign cred_err = err_q;

endmodule

// File: tb/tb_rr_pkt_arb.sv
// Directed self-checking bench for rr_pkt_arb (PORT=4, CRED=4, CW=3).
module tb_rr_pkt_arb;

  logic       clk;
  logic       rst_;
  logic [4:0] req;
  logic [4:0] tail;
  logic       cred_in;
  logic [4:0] grt;
  logic       busy;
  logic       fire;
  logic [2:0] cred_cnt;
  logic       cred_err;

  int n_chk  = 0;
  int n_fail = 0;

  rr_pkt_arb #(.PORT(4), .CRED(4), .CW(3)) dut (
    .clk      (clk),
    .rst_     (rst_),
    .req      (req),
    .tail     (tail),
    .cred_in  (cred_in),
    .grt      (grt),
    .busy     (busy),
    .fire     (fire),
    .cred_cnt (cred_cnt),
    .cred_err (cred_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [4:0] r, input logic [4:0] t, input logic c);
    req     = r;
    tail    = t;
    cred_in = c;
    #1;
  endtask

  task automatic do_reset();
    rst_ = 1'b1;
    set_in(5'b00000, 5'b00000, 1'b0);
    tick();
    rst_ = 1'b0;
  endtask

  initial begin
    rst_ = 1'b1;
    set_in(5'b11111, 5'b00000, 1'b0);
    tick();
    // Reset values, with requests present during reset
    chk("rst_grt",  32'(grt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_fire", 32'(fire), 32'h0);
    chk("rst_cnt",  32'(cred_cnt), 32'h4);
    chk("rst_err",  32'(cred_err), 32'h0);
    tick();
    chk("rst_hold_grt", 32'(grt), 32'h0);

    // Round-robin order from ptr after a grant
    rst_ = 1'b0;
    set_in(5'b10100, 5'b00000, 1'b0);
    chk("rr_idle_grt", 32'(grt), 32'h0);
    tick();
    chk("rr_grt2", 32'(grt), 32'h04);
    chk("rr_busy", 32'(busy), 32'h1);
    chk("rr_fire", 32'(fire), 32'h1);
    set_in(5'b10100, 5'b00100, 1'b0);
    tick();
    chk("rr_rel_grt", 32'(grt), 32'h0);
    chk("rr_rel_busy", 32'(busy), 32'h0);
    chk("rr_rel_cnt", 32'(cred_cnt), 32'h3);
    set_in(5'b10100, 5'b00000, 1'b0);
    chk("rr_bubble_fire", 32'(fire), 32'h0);
    tick();
    chk("rr_grt4", 32'(grt), 32'h10);

    // Single-flit packet
    do_reset();
    set_in(5'b00001, 5'b00001, 1'b0);
    tick();
    chk("sf_grt", 32'(grt), 32'h01);
    chk("sf_fire", 32'(fire), 32'h1);
    tick();
    chk("sf_rel_grt", 32'(grt), 32'h0);
    chk("sf_cnt", 32'(cred_cnt), 32'h3);
    chk("sf_idle_fire", 32'(fire), 32'h0);
    tick();
    chk("sf_regrant", 32'(grt), 32'h01);

    // Credit starvation; non-owner tails must be ignored
    do_reset();
    set_in(5'b00010, 5'b11101, 1'b0);
    tick();
    chk("cs_grt", 32'(grt), 32'h02);
    for (int i = 0; i < 4; i++) begin
      chk("cs_fire", 32'(fire), 32'h1);
      tick();
    end
    chk("cs_cnt0", 32'(cred_cnt), 32'h0);
    chk("cs_nofire", 32'(fire), 32'h0);
    tick();
    chk("cs_grt_held", 32'(grt), 32'h02);
    chk("cs_nofire2", 32'(fire), 32'h0);
    set_in(5'b00010, 5'b11101, 1'b1);
    tick();
    set_in(5'b00010, 5'b11101, 1'b0);
    chk("cs_cnt1", 32'(cred_cnt), 32'h1);
    chk("cs_onefire", 32'(fire), 32'h1);
    tick();
    chk("cs_cnt_end", 32'(cred_cnt), 32'h0);
    chk("cs_fire_end", 32'(fire), 32'h0);
    chk("cs_grt_end", 32'(grt), 32'h02);

    // Simultaneous credit/fire, then overflow saturation and sticky error
    do_reset();
    set_in(5'b00001, 5'b00000, 1'b0);
    tick();
    tick();
    tick();
    chk("cr_cnt2", 32'(cred_cnt), 32'h2);
    set_in(5'b00001, 5'b00000, 1'b1);
    chk("cr_fire_both", 32'(fire), 32'h1);
    tick();
    chk("cr_both_cnt", 32'(cred_cnt), 32'h2);
    set_in(5'b00000, 5'b00000, 1'b1);
    tick();
    tick();
    chk("cr_cnt4", 32'(cred_cnt), 32'h4);
    chk("cr_err_pre", 32'(cred_err), 32'h0);
    tick();
    chk("cr_sat_cnt", 32'(cred_cnt), 32'h4);
    chk("cr_err_set", 32'(cred_err), 32'h1);
    set_in(5'b00000, 5'b00000, 1'b0);
    tick();
    tick();
    chk("cr_err_sticky", 32'(cred_err), 32'h1);
    chk("cr_grt_held", 32'(grt), 32'h01);

    // Mid-packet reset
    do_reset();
    set_in(5'b01000, 5'b00000, 1'b0);
    tick();
    tick();
    tick();
    tick();
    chk("mr_grt", 32'(grt), 32'h08);
    chk("mr_cnt1", 32'(cred_cnt), 32'h1);
    rst_ = 1'b1;
    set_in(5'b11111, 5'b00000, 1'b0);
    tick();
    chk("mr_grt0", 32'(grt), 32'h0);
    chk("mr_cnt4", 32'(cred_cnt), 32'h4);
    chk("mr_busy", 32'(busy), 32'h0);
    rst_ = 1'b0;
    tick();
    chk("mr_ptr0_grt", 32'(grt), 32'h01);

    // Owner drops req mid-packet while others request
    do_reset();
    set_in(5'b00100, 5'b00000, 1'b0);
    tick();
    tick();
    chk("wh_cnt3", 32'(cred_cnt), 32'h3);
    set_in(5'b11011, 5'b11011, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("wh_fire0", 32'(fire), 32'h0);
      chk("wh_grt", 32'(grt), 32'h04);
      tick();
    end
    chk("wh_grt_after", 32'(grt), 32'h04);
    chk("wh_cnt_after", 32'(cred_cnt), 32'h3);
    set_in(5'b00100, 5'b00100, 1'b0);
    chk("wh_tail_fire", 32'(fire), 32'h1);
    tick();
    chk("wh_rel", 32'(grt), 32'h0);
    set_in(5'b11011, 5'b00000, 1'b0);
    tick();
    chk("wh_next_grt", 32'(grt), 32'h08);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
